// File: rtl/dmem_responder_pkg.sv
// Shared defines for the data-memory responder: bus widths, FSM state encodings
// and the store byte-mask legality rule.
package dmem_responder_pkg;

   localparam int ADDR_SIZE = 32;
   localparam int XLEN      = 32;

   // Encodings are visible to the core's stall logic, so they are fixed values.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } dmemState_t;

   // Byte, aligned halfword and full word stores are the only legal lane patterns.
   function automatic logic ampLegal(input logic [3:0] mask);
      case (mask)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: ampLegal = 1'b1;
         default:                   ampLegal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the xgriscv core (master) and the memory responder (slave).
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic                 req;
   logic                 memwrite;
   logic [3:0]           amp;
   logic [ADDR_SIZE-1:0] daddr;
   logic [XLEN-1:0]      writedata;
   logic [XLEN-1:0]      readdata;
   logic                 ack;
   logic                 busy;
   logic                 err;

   modport master (
      output req, memwrite, amp, daddr, writedata,
      input  readdata, ack, busy, err
   );

   modport slave (
      input  req, memwrite, amp, daddr, writedata,
      output readdata, ack, busy, err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a synchronous, read-enabled
// output register that holds its value between reads.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack slave with programmable wait states, byte-masked
// writes, full-word reads and illegal-access flagging.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for req; request fields latched on acceptance
// WAIT   | counting down wait states, leaves when the counter is at 1
// ACCESS | array write commits / read word captured at the exit edge
// RESP   | one-cycle ack (with err for a rejected access)
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_SIZE-3:0] DEPTH_IDX = (ADDR_SIZE-2)'(DEPTH_WORDS);
   localparam logic [3:0]           WAIT_LOAD = 4'(WAIT_CYCLES);

   dmemState_t           state;
   dmemState_t           stateNext;
   logic [3:0]           waitCnt;
   logic [3:0]           cntNext;
   logic                 accept;

   logic                 latWrite;
   logic [3:0]           latAmp;
   logic [ADDR_SIZE-3:0] latIdx;
   logic [XLEN-1:0]      latData;

   logic                 illegal;
   logic                 rdZero;
   logic [3:0]           arrWe;
   logic                 arrRe;
   logic [31:0]          arrQ;
   logic                 ackO;
   logic                 busyO;
   logic                 errO;

   assign illegal = (latIdx >= DEPTH_IDX) || (latWrite && !ampLegal(latAmp));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         waitCnt  <= '0;
         rdZero   <= 1'b1;
         latWrite <= 1'b0;
         latAmp   <= '0;
         latIdx   <= '0;
         latData  <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= cntNext;
         if (accept) begin
            latWrite <= bus.memwrite;
            latAmp   <= bus.amp;
            latIdx   <= bus.daddr[ADDR_SIZE-1:2];
            latData  <= bus.writedata;
         end
         // rdZero masks the RAM output after reset and for out-of-range reads.
         if (state == ACCESS && !latWrite) begin
            rdZero <= illegal;
         end
      end
   end

   always_comb begin
      stateNext = state;
      cntNext   = waitCnt;
      accept    = 1'b0;
      arrWe     = '0;
      arrRe     = 1'b0;
      ackO      = 1'b0;
      busyO     = 1'b1;
      errO      = 1'b0;
      case (state)
         IDLE: begin
            busyO = 1'b0;
            if (bus.req) begin
               accept    = 1'b1;
               cntNext   = WAIT_LOAD;
               stateNext = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            cntNext = waitCnt - 4'd1;
            if (waitCnt <= 4'd1) begin
               stateNext = ACCESS;
            end
         end
         ACCESS: begin
            // Gated with reset so an abort at this edge leaves the array untouched.
            if (reset && !illegal) begin
               if (latWrite) begin
                  arrWe = latAmp;
               end else begin
                  arrRe = 1'b1;
               end
            end
            stateNext = RESP;
         end
         RESP: begin
            ackO      = 1'b1;
            errO      = illegal;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) uArray (
      .clk   (clk),
      .we    (arrWe),
      .re    (arrRe),
      .addr  (latIdx[AW-1:0]),
      .wdata (latData),
      .rdata (arrQ)
   );

   assign bus.readdata = rdZero ? '0 : arrQ;
   assign bus.ack      = ackO;
   assign bus.busy     = busyO;
   assign bus.err      = errO;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        tbReq   = 1'b0;
   logic        tbWrite = 1'b0;
   logic [3:0]  tbAmp   = '0;
   logic [31:0] tbAddr  = '0;
   logic [31:0] tbWdata = '0;
   logic        sel     = 1'b0;

   int nCompared   = 0;
   int nMismatched = 0;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   assign bus2.req       = tbReq & ~sel;
   assign bus2.memwrite  = tbWrite;
   assign bus2.amp       = tbAmp;
   assign bus2.daddr     = tbAddr;
   assign bus2.writedata = tbWdata;
   assign bus0.req       = tbReq & sel;
   assign bus0.memwrite  = tbWrite;
   assign bus0.amp       = tbAmp;
   assign bus0.daddr     = tbAddr;
   assign bus0.writedata = tbWdata;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) uDut2 (
      .clk(clk), .reset(reset), .bus(bus2));
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) uDut0 (
      .clk(clk), .reset(reset), .bus(bus0));

   logic        ackObs, busyObs, errObs;
   logic [31:0] rdObs;
   assign ackObs  = sel ? bus0.ack      : bus2.ack;
   assign busyObs = sel ? bus0.busy     : bus2.busy;
   assign errObs  = sel ? bus0.err      : bus2.err;
   assign rdObs   = sel ? bus0.readdata : bus2.readdata;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request, scrambles the inputs after acceptance, and checks latency,
   // busy coverage and the single-cycle ack pulse.
   task automatic doTxn(input string tag, input logic wr, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
      int   lat;
      int   wExp;
      logic busyOk;
      wExp   = sel ? 0 : 2;
      lat    = 0;
      busyOk = 1'b1;
      rd     = '0;
      e      = 1'b0;
      @(negedge clk);
      tbReq = 1'b1; tbWrite = wr; tbAmp = m; tbAddr = a; tbWdata = d;
      @(posedge clk);
      @(negedge clk);
      tbReq = 1'b0; tbWrite = ~wr; tbAmp = ~m; tbAddr = a ^ 32'h4; tbWdata = ~d;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge clk);
         if (!busyObs) busyOk = 1'b0;
         if (ackObs) begin
            lat = n;
            rd  = rdObs;
            e   = errObs;
            break;
         end
      end
      checkVal({tag, "_lat"}, 32'(lat), 32'(wExp + 2));
      checkVal({tag, "_busy"}, {31'b0, busyOk}, 32'd1);
      @(negedge clk);
      checkVal({tag, "_ackoff"}, {30'b0, ackObs, busyObs}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      int          nAck;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkVal("rst_ack",  {31'b0, bus2.ack},  32'd0);
      checkVal("rst_busy", {31'b0, bus2.busy}, 32'd0);
      checkVal("rst_err",  {31'b0, bus2.err},  32'd0);
      checkVal("rst_rd2",  bus2.readdata, 32'd0);
      checkVal("rst_rd0",  bus0.readdata, 32'd0);
      reset = 1'b1;

      doTxn("rd10", 1'b0, 4'hF, 32'h10, 32'h0, rd, e);
      checkVal("rd10_err", {31'b0, e}, 32'd0);

      doTxn("wr20a", 1'b1, 4'b1111, 32'h20, 32'hAABBCCDD, rd, e);
      checkVal("wr20a_err", {31'b0, e}, 32'd0);
      doTxn("wr20b", 1'b1, 4'b0010, 32'h20, 32'h00001100, rd, e);
      doTxn("rd20", 1'b0, 4'b0000, 32'h20, 32'h0, rd, e);
      checkVal("rd20_data", rd, 32'hAABB11DD);
      checkVal("rd20_err", {31'b0, e}, 32'd0);

      doTxn("wr24", 1'b1, 4'b1111, 32'h24, 32'h12345678, rd, e);
      doTxn("wr24bad", 1'b1, 4'b0101, 32'h24, 32'hFFFFFFFF, rd, e);
      checkVal("wr24bad_err", {31'b0, e}, 32'd1);
      checkVal("rd_hold_wr", rd, 32'hAABB11DD);
      doTxn("rd24", 1'b0, 4'b1111, 32'h24, 32'h0, rd, e);
      checkVal("rd24_data", rd, 32'h12345678);

      doTxn("wr28", 1'b1, 4'b1111, 32'h28, 32'hCAFEF00D, rd, e);
      doTxn("wr28hi", 1'b1, 4'b1100, 32'h28, 32'h12340000, rd, e);
      checkVal("wr28hi_err", {31'b0, e}, 32'd0);
      doTxn("rd28", 1'b0, 4'b0000, 32'h28, 32'h0, rd, e);
      checkVal("rd28_data", rd, 32'h1234F00D);

      doTxn("rdOob", 1'b0, 4'b1111, 32'h1000, 32'h0, rd, e);
      checkVal("rdOob_err", {31'b0, e}, 32'd1);
      checkVal("rdOob_data", rd, 32'd0);
      doTxn("wrLast", 1'b1, 4'b1111, 32'hFFC, 32'h5A5A0001, rd, e);
      checkVal("wrLast_err", {31'b0, e}, 32'd0);
      doTxn("rdLast", 1'b0, 4'b1111, 32'hFFC, 32'h0, rd, e);
      checkVal("rdLast_data", rd, 32'h5A5A0001);
      checkVal("rdLast_err", {31'b0, e}, 32'd0);

      sel = 1'b1;
      doTxn("z_wr30", 1'b1, 4'b1111, 32'h30, 32'hA5A5A5A5, rd, e);
      doTxn("z_rd30", 1'b0, 4'b0000, 32'h30, 32'h0, rd, e);
      checkVal("z_rd30_data", rd, 32'hA5A5A5A5);
      checkVal("z_rd30_err", {31'b0, e}, 32'd0);

      @(negedge clk);
      tbReq = 1'b1; tbWrite = 1'b1; tbAmp = 4'b1111; tbAddr = 32'h34; tbWdata = 32'h11111111;
      @(posedge clk);
      nAck = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) tbWdata = 32'h22222222;
         if (n == 3) tbReq = 1'b0;
         if (ackObs) nAck++;
      end
      checkVal("z_drop_acks", 32'(nAck), 32'd1);
      doTxn("z_rd34", 1'b0, 4'b1111, 32'h34, 32'h0, rd, e);
      checkVal("z_rd34_data", rd, 32'h11111111);

      sel = 1'b0;
      doTxn("wr40", 1'b1, 4'b1111, 32'h40, 32'h01020304, rd, e);
      @(negedge clk);
      tbReq = 1'b1; tbWrite = 1'b1; tbAmp = 4'b1111; tbAddr = 32'h40; tbWdata = 32'hDEADBEEF;
      @(posedge clk);
      @(negedge clk);
      tbReq = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      checkVal("mrst_busy", {31'b0, busyObs}, 32'd0);
      checkVal("mrst_rd", rdObs, 32'd0);
      nAck = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (ackObs) nAck++;
      end
      checkVal("mrst_acks", 32'(nAck), 32'd0);
      doTxn("rd40", 1'b0, 4'b1111, 32'h40, 32'h0, rd, e);
      checkVal("rd40_data", rd, 32'h01020304);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
